maskable_carry_pipe_adder: RTL and testbench

MASKABLE_CARRY_PIPE_ADDER -- requirements
Module: maskable_carry_pipe_adder

---
 rtl/mca_pkg.sv | 12 +
 rtl/maskable_seg_adder.sv | 32 +++
 rtl/maskable_carry_pipe_adder.sv | 155 +++++++++++++++
 tb/tb_maskable_carry_pipe_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mca_pkg.sv
// Shared constants and helpers for the maskable-carry pipelined adder.
package mca_pkg;

  localparam int MCA_WIDTH_DEF = 16;
  localparam int MCA_SEG_DEF   = 4;

  // A non-positive segment width is rejected by the top; return 1 so elaboration reaches that check.
  function automatic int mca_stages(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction

endpackage

// File: rtl/maskable_seg_adder.sv
// Combinational SEG-bit ripple slice: exact full adder where mask=1,
// carry-dropping approximate cell (xor sum, and carry-out) where mask=0.
module maskable_seg_adder
  import mca_pkg::*;
#(
  parameter int SEG = MCA_SEG_DEF
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic [SEG-1:0] mask,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  always_comb begin : p_ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      if (mask[i]) begin
        sum[i] = a[i] ^ b[i] ^ c;
        c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end else begin
        sum[i] = a[i] ^ b[i];
        c      = a[i] & b[i];
      end
    end
    cout = c;
  end

endmodule

// File: rtl/maskable_carry_pipe_adder.sv
// Pipelined adder with a per-bit carry mask, one SEG-bit segment resolved per stage.
// Optional exact-reference comparison and err output enabled by macro MCA_ERR_FLAG_EN.
module maskable_carry_pipe_adder
  import mca_pkg::*;
#(
  parameter int WIDTH = MCA_WIDTH_DEF,
  parameter int SEG   = MCA_SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef MCA_ERR_FLAG_EN
  ,
  output logic             err
`endif
);

  localparam int STAGES = mca_stages(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("maskable_carry_pipe_adder: WIDTH must be a positive multiple of SEG");
  end

  logic en;

  logic [STAGES-1:0]            v_q, c_q, v_src, c_src, seg_cout;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, m_q, s_q;
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, m_src, s_src, s_nxt;
  logic [STAGES-1:0][SEG-1:0]   seg_sum;

  assign en        = !v_q[LAST] | out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[LAST];
  assign sum       = {c_q[LAST], s_q[LAST]};

  // Stage k consumes the port operands (k=0) or the registers of stage k-1.
  always_comb begin
    v_src[0] = in_valid;
    c_src[0] = 1'b0;
    a_src[0] = a;
    b_src[0] = b;
    m_src[0] = mask;
    s_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      m_src[k] = m_q[k-1];
      s_src[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    maskable_seg_adder #(.SEG(SEG)) u_seg (
      .a    (a_src[k][k*SEG +: SEG]),
      .b    (b_src[k][k*SEG +: SEG]),
      .mask (m_src[k][k*SEG +: SEG]),
      .cin  (c_src[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k]                = s_src[k];
      s_nxt[k][k*SEG +: SEG]  = seg_sum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      s_q <= '0;
    end else if (en) begin
      v_q <= v_src;
      c_q <= seg_cout;
      a_q <= a_src;
      b_q <= b_src;
      m_q <= m_src;
      s_q <= s_nxt;
    end
  end

  // Operand bits held in the final stage have all been consumed already.
  logic unused_tail;
  assign unused_tail = ^{a_q[LAST], b_q[LAST], m_q[LAST]};

`ifdef MCA_ERR_FLAG_EN
  logic [STAGES-1:0]            rc_q, rc_src, ref_cout;
  logic [STAGES-1:0][WIDTH-1:0] r_q, r_src, r_nxt;
  logic [STAGES-1:0][SEG-1:0]   ref_sum;
  logic                         err_q;

  always_comb begin
    rc_src[0] = 1'b0;
    r_src[0]  = '0;
    for (int k = 1; k < STAGES; k++) begin
      rc_src[k] = rc_q[k-1];
      r_src[k]  = r_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_ref
    maskable_seg_adder #(.SEG(SEG)) u_ref (
      .a    (a_src[k][k*SEG +: SEG]),
      .b    (b_src[k][k*SEG +: SEG]),
      .mask ({SEG{1'b1}}),
      .cin  (rc_src[k]),
      .sum  (ref_sum[k]),
      .cout (ref_cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      r_nxt[k]               = r_src[k];
      r_nxt[k][k*SEG +: SEG] = ref_sum[k];
    end
  end

  // err is decided as the result enters the output stage, so it travels with sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q  <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else if (en) begin
      rc_q  <= ref_cout;
      r_q   <= r_nxt;
      err_q <= v_src[LAST] &&
               ({ref_cout[LAST], r_nxt[LAST]} != {seg_cout[LAST], s_nxt[LAST]});
    end
  end

  assign err = err_q;

  logic unused_ref_tail;
  assign unused_ref_tail = ^{rc_q[LAST], r_q[LAST]};
`endif

endmodule

// File: tb/tb_maskable_carry_pipe_adder.sv
// Directed self-checking bench for maskable_carry_pipe_adder (WIDTH=16, SEG=4).
module tb_maskable_carry_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] sum;
`ifdef MCA_ERR_FLAG_EN
  logic        err;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [16:0] got[$];

  maskable_carry_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef MCA_ERR_FLAG_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] mask;
    logic [16:0] sum;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Records the output transfer that happens on the coming edge, then moves 1ns past it.
  task automatic step;
    if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(sum);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int n;
    a        = v.a;
    b        = v.b;
    mask     = v.mask;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    t0 = cyc;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({v.name, "_latency"}, 32'(cyc - t0), 32'd4);
    chk({v.name, "_sum"}, 32'(sum), 32'(v.sum));
`ifdef MCA_ERR_FLAG_EN
    chk({v.name, "_err"}, 32'(err), 32'(v.err));
`endif
    step();
  endtask

  initial begin
    logic [16:0] held;
    logic [16:0] exp_q[$];
    logic [15:0] sa, sb;
    int          sent;
    int          n;
    logic        stale;
    vec_t        pv;

    vecs[0] = '{16'h00FF, 16'h0001, 16'hFFFF, 17'h00100, 1'b0, "exact_carry_chain"};
    vecs[1] = '{16'h00FF, 16'h0001, 16'hFFFD, 17'h000FE, 1'b1, "bit1_drops_carry"};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 17'h0FFFE, 1'b1, "all_approx"};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFFF, 17'h10000, 1'b0, "exact_overflow"};
    vecs[4] = '{16'h1234, 16'h4321, 16'hFFFF, 17'h05555, 1'b0, "exact_no_carry"};
    vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 17'h10000, 1'b0, "approx_msb_carry"};
    vecs[6] = '{16'h0F0F, 16'h00F1, 16'hF0F0, 17'h00FFE, 1'b1, "mixed_mask"};
    vecs[7] = '{16'h0000, 16'h0000, 16'hFFFF, 17'h00000, 1'b0, "zero"};

    @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back stream with a 3-cycle downstream stall in the middle.
    got.delete();
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      sa = 16'(i * 16'h2345 + 16'h0111);
      sb = 16'hF00F ^ 16'(i);
      exp_q.push_back({1'b0, sa} + {1'b0, sb});
    end
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        a        = 16'(sent * 16'h2345 + 16'h0111);
        b        = 16'hF00F ^ 16'(sent);
        mask     = 16'hFFFF;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        if (c == 5) held = sum;
        else chk("stall_sum_hold", 32'(sum), 32'(held));
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("stream_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk($sformatf("stream_order_%0d", i), 32'(got[i]), 32'(exp_q[i]));
    end

    // Reset with three operands in flight; the operand offered in the reset cycle is dropped.
    got.delete();
    out_ready = 1'b1;
    mask      = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 16'(16'h0101 * (i + 1));
      b        = 16'h0303;
      step();
    end
    a        = 16'h7777;
    b        = 16'h1111;
    in_valid = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("inflight_rst_out_valid", 32'(out_valid), 32'd0);
    chk("inflight_rst_sum", 32'(sum), 32'd0);
    chk("inflight_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MCA_ERR_FLAG_EN
    chk("inflight_rst_err", 32'(err), 32'd0);
`endif
    stale = 1'b0;
    repeat (6) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      step();
    end
    chk("inflight_rst_no_stale", 32'(stale), 32'd0);
    chk("inflight_rst_no_transfer", 32'(got.size()), 32'd0);
    pv = '{16'h7777, 16'h1111, 16'hFFFF, 17'h08888, 1'b0, "post_rst_transfer"};
    run_vec(pv);

    // Consecutive transfers with different masks keep their own masks.
    got.delete();
    out_ready = 1'b1;
    a         = 16'h00FF;
    b         = 16'h0001;
    mask      = 16'hFFFF;
    in_valid  = 1'b1;
    step();
    mask = 16'h0000;
    step();
    in_valid = 1'b0;
    n = 0;
    while (got.size() < 2 && n < 20) begin
      step();
      n++;
    end
    chk("mask_change_count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk("mask_change_exact", 32'(got[0]), 32'h00100);
      chk("mask_change_approx", 32'(got[1]), 32'h000FE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
